mvu_sum_accu: RTL and testbench

- Downstream consumer of the pipelined multi-input adder tree (add_multi) in the MVU datapath.
- Accumulates BEATS consecutive partial sums into one dot-product result.
- Emits each result on a valid/ready output stream through a 2-entry output queue.
- Drives back-pressure upstream via in_rdy, which the MVU ties into the adder tree's en.

---
 rtl/mvu_pkg.sv | 23 ++
 rtl/mvu_queue2.sv | 50 +++++
 rtl/mvu_sum_accu.sv | 80 ++++++++
 tb/tb_mvu_sum_accu.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_pkg.sv
// Shared MVU sizing helpers and defaults used by the adder tree and its accumulator.
// Pure constants and constant functions; no logic.
package mvu_pkg;

   localparam int MVU_BEATS = 4;

   function automatic int bitwidth(input int value);
      return $clog2(value + 1);
   endfunction

   function automatic int sumwidth(input int in_width, input int n_inputs);
      return in_width + $clog2(n_inputs);
   endfunction

   // The partial sum already carries its sign bit, so signedness adds no extra bit.
   function automatic int accwidth(input int sum_width, input int beats, input bit is_signed);
      int w;
      w = sum_width + $clog2(beats);
      if (is_signed) return w;
      return w;
   endfunction

endpackage

// File: rtl/mvu_queue2.sv
// Two-entry registered FIFO: push result is visible on dout the next cycle.
// Push is ignored when full unless a pop frees the head in the same cycle.
module mvu_queue2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       cnt;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == 2'd0);
   assign full    = (cnt == 2'd2);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/mvu_sum_accu.sv
// Accumulates BEATS partial sums per result; result is valid one cycle after the last beat.
// in_rdy drops only for a last beat while both queue entries are held; built from registered state only.
module mvu_sum_accu
   import mvu_pkg::*;
#(
   parameter int SUM_WIDTH = 8,
   parameter bit SIGNED    = 1'b1,
   parameter int BEATS     = MVU_BEATS,
   parameter int ACC_WIDTH = accwidth(SUM_WIDTH, BEATS, SIGNED)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SUM_WIDTH-1:0] sum,
   input  logic                 in_vld,
   output logic                 in_rdy,
   output logic [ACC_WIDTH-1:0] out_dat,
   output logic                 out_vld,
   input  logic                 out_rdy,
   output logic                 out_last
);

   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int EW = (ACC_WIDTH > SUM_WIDTH) ? ACC_WIDTH : SUM_WIDTH;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   logic [CW-1:0]        beat;
   logic [ACC_WIDTH-1:0] acc;
   logic [EW-1:0]        ext_w;
   logic [ACC_WIDTH-1:0] ext;
   logic [ACC_WIDTH-1:0] nxt;
   logic                 live;
   logic                 is_last;
   logic                 xfer;
   logic                 q_full;
   logic                 q_empty;

   always_comb begin
      ext_w = '0;
      if (SIGNED) ext_w = EW'($signed(sum));
      else        ext_w = EW'(sum);
   end

   assign ext     = ext_w[ACC_WIDTH-1:0];
   assign is_last = (beat == LAST_BEAT);
   // live holds in_rdy low until the first edge after reset release.
   assign in_rdy  = live && (!q_full || !is_last);
   assign xfer    = in_vld && in_rdy;
   assign nxt     = (beat == '0) ? ext : acc + ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat <= '0;
         acc  <= '0;
         live <= 1'b0;
      end else begin
         live <= 1'b1;
         if (xfer) begin
            acc  <= nxt;
            beat <= is_last ? '0 : beat + 1'b1;
         end
      end
   end

   mvu_queue2 #(
      .WIDTH (ACC_WIDTH)
   ) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (xfer && is_last),
      .din   (nxt),
      .pop   (out_vld && out_rdy),
      .dout  (out_dat),
      .full  (q_full),
      .empty (q_empty)
   );

   assign out_vld  = !q_empty;
   assign out_last = 1'b1;

endmodule

// File: tb/tb_mvu_sum_accu.sv
// Five accumulator configurations driven from one clock; a scoreboard monitor checks every popped result.
module tb_mvu_sum_accu;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] sum [5];
   logic vld [5], ordy [5], ir [5], ov [5], ol [5];
   logic [9:0] od0;
   logic [7:0] od1;
   logic [8:0] od2;
   logic [7:0] od3;
   logic [9:0] od4;
   logic [15:0] od [5];

   assign od[0] = 16'(od0);
   assign od[1] = 16'(od1);
   assign od[2] = 16'(od2);
   assign od[3] = 16'(od3);
   assign od[4] = 16'(od4);

   mvu_sum_accu #(.SUM_WIDTH(8), .SIGNED(1'b1), .BEATS(4)) u_a (
      .clk(clk), .rst_n(rst_n), .sum(sum[0]), .in_vld(vld[0]), .in_rdy(ir[0]),
      .out_dat(od0), .out_vld(ov[0]), .out_rdy(ordy[0]), .out_last(ol[0]));
   mvu_sum_accu #(.SUM_WIDTH(8), .SIGNED(1'b1), .BEATS(1)) u_b (
      .clk(clk), .rst_n(rst_n), .sum(sum[1]), .in_vld(vld[1]), .in_rdy(ir[1]),
      .out_dat(od1), .out_vld(ov[1]), .out_rdy(ordy[1]), .out_last(ol[1]));
   mvu_sum_accu #(.SUM_WIDTH(8), .SIGNED(1'b1), .BEATS(2)) u_c (
      .clk(clk), .rst_n(rst_n), .sum(sum[2]), .in_vld(vld[2]), .in_rdy(ir[2]),
      .out_dat(od2), .out_vld(ov[2]), .out_rdy(ordy[2]), .out_last(ol[2]));
   mvu_sum_accu #(.SUM_WIDTH(8), .SIGNED(1'b0), .BEATS(2), .ACC_WIDTH(8)) u_d (
      .clk(clk), .rst_n(rst_n), .sum(sum[3]), .in_vld(vld[3]), .in_rdy(ir[3]),
      .out_dat(od3), .out_vld(ov[3]), .out_rdy(ordy[3]), .out_last(ol[3]));
   mvu_sum_accu #(.SUM_WIDTH(8), .SIGNED(1'b1), .BEATS(3)) u_e (
      .clk(clk), .rst_n(rst_n), .sum(sum[4]), .in_vld(vld[4]), .in_rdy(ir[4]),
      .out_dat(od4), .out_vld(ov[4]), .out_rdy(ordy[4]), .out_last(ol[4]));

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] exp_q [5][$];
   int     cnt_m [5];
   longint tot_m [5];
   bit     done = 1'b0;

   function automatic int beats_of(input int k);
      case (k)
         0: return 4;
         1: return 1;
         2: return 2;
         3: return 2;
         default: return 3;
      endcase
   endfunction

   function automatic bit signed_of(input int k);
      return (k != 3);
   endfunction

   function automatic int width_of(input int k);
      case (k)
         0: return 10;
         1: return 8;
         2: return 9;
         3: return 8;
         default: return 10;
      endcase
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: sum the extended beats in plain integers, reduce modulo 2^width at group end.
   task automatic model_beat(input int k, input logic [7:0] v);
      longint x;
      longint m;
      x = signed_of(k) ? longint'($signed(v)) : longint'(v);
      tot_m[k] += x;
      cnt_m[k]++;
      if (cnt_m[k] == beats_of(k)) begin
         m = tot_m[k] & ((64'd1 << width_of(k)) - 1);
         exp_q[k].push_back(16'(m));
         cnt_m[k] = 0;
         tot_m[k] = 0;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the accepting edge.
   task automatic send(input int k, input logic [7:0] v);
      logic r;
      int   n;
      n = 0;
      sum[k] = v;
      vld[k] = 1'b1;
      forever begin
         r = ir[k];
         @(posedge clk);
         #1;
         if (r) break;
         n++;
         if (n > 500) break;
      end
      vld[k] = 1'b0;
      if (n > 500) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: instance %0d never ready", k);
      end else begin
         model_beat(k, v);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      logic [15:0] e;
      if (rst_n) begin
         for (int k = 0; k < 5; k++) begin
            if (ov[k] && ordy[k]) begin
               if (exp_q[k].size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_output: instance %0d got %0d, expected none", k, od[k]);
               end else begin
                  e = exp_q[k].pop_front();
                  check($sformatf("result_%0d", k), longint'(od[k]), longint'(e));
               end
            end
         end
      end
   end

   initial begin
      int n;
      for (int k = 0; k < 5; k++) begin
         sum[k] = '0; vld[k] = 1'b0; ordy[k] = 1'b1; cnt_m[k] = 0; tot_m[k] = 0;
      end
      #1;
      check("reset_out_vld", longint'(ov[0]), 0);
      check("reset_out_dat", longint'(od[0]), 0);
      check("reset_in_rdy", longint'(ir[0]), 0);
      #21 rst_n = 1'b1;
      #1 check("in_rdy_before_edge", longint'(ir[0]), 0);
      @(posedge clk);
      #1 check("in_rdy_after_edge", longint'(ir[0]), 1);
      check("out_last", longint'(ol[0]), 1);

      // Four back-to-back signed beats.
      send(0, 8'd10);
      check("t1_rdy", longint'(ir[0]), 1);
      send(0, 8'hFD);
      check("t1_rdy", longint'(ir[0]), 1);
      send(0, 8'd7);
      check("t1_rdy", longint'(ir[0]), 1);
      check("t1_no_early_vld", longint'(ov[0]), 0);
      send(0, 8'd1);
      check("t1_rdy", longint'(ir[0]), 1);
      check("t1_vld", longint'(ov[0]), 1);
      check("t1_dat", longint'(od[0]), 15);
      cycles(2);

      // Single-beat groups stream one result per cycle.
      send(1, 8'h80);
      check("t2_dat0", longint'(od[1]), 128);
      send(1, 8'h7F);
      check("t2_dat1", longint'(od[1]), 127);
      send(1, 8'h00);
      check("t2_dat2", longint'(od[1]), 0);
      check("t2_vld", longint'(ov[1]), 1);
      cycles(2);

      // Back-pressure: two results fill the queue, the third group's last beat stalls.
      ordy[2] = 1'b0;
      for (int i = 0; i < 5; i++) send(2, 8'd1);
      check("t3_vld", longint'(ov[2]), 1);
      check("t3_head", longint'(od[2]), 2);
      check("t3_stall", longint'(ir[2]), 0);
      cycles(3);
      check("t3_still_stalled", longint'(ir[2]), 0);
      check("t3_head_stable", longint'(od[2]), 2);
      ordy[2] = 1'b1;
      send(2, 8'd1);
      cycles(4);
      check("t3_drained", longint'(ov[2]), 0);

      // Unsigned wrap at 8 bits.
      send(3, 8'd200);
      send(3, 8'd100);
      check("t4_wrap", longint'(od[3]), 44);
      cycles(3);

      // Asynchronous reset mid-group discards the partial sum.
      send(0, 8'd5);
      send(0, 8'd5);
      #3 rst_n = 1'b0;
      #1;
      check("t5_vld_in_reset", longint'(ov[0]), 0);
      check("t5_rdy_in_reset", longint'(ir[0]), 0);
      for (int k = 0; k < 5; k++) begin
         exp_q[k].delete();
         cnt_m[k] = 0;
         tot_m[k] = 0;
      end
      #7 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) send(0, 8'd1);
      check("t5_after_reset", longint'(od[0]), 4);
      cycles(2);

      // Randomised groups with input gaps and random downstream stalls.
      fork
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               ordy[4] = 1'($urandom_range(0, 1));
            end
            ordy[4] = 1'b1;
         end
      join_none
      for (int g = 0; g < 137; g++) begin
         for (int b = 0; b < 3; b++) begin
            cycles($urandom_range(0, 2));
            send(4, 8'($urandom));
         end
      end
      done = 1'b1;
      n = 0;
      while ((exp_q[4].size() != 0 || ov[4] || !ordy[4]) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      cycles(3);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("leftover_expected_%0d", k), longint'(exp_q[k].size()), 0);
         check($sformatf("trailing_vld_%0d", k), longint'(ov[k]), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
